i2s_dac_tx: RTL and testbench
=============================

// Module: i2s_dac_tx
// PURPOSE
// Serial transmitter that takes 16-bit samples from the wave generator and sends them to the audio codec DAC.
// Uses standard I2S framing: o_bclk, o_lrck and o_sdata are all generated on-chip.
// Sits between o_wave_out and the codec pins. It pulls samples through a one-entry valid/ready buffer, one sample pair per frame.
// One clock (i_clk, normally the 12 MHz codec clock). Reset is synchronous and active-high (i_rst).
// PARAMETERS
// DATA_W     16  sample width; must be <= SLOT_W-1
// SLOT_W     32  BCLK periods per channel slot; frame = 2*SLOT_W periods
// BCLK_DIV    4  i_clk cycles per BCLK period; even, >= 2
// SIGN_FLIP   0  1: invert the sample MSB on load (offset-binary to two's complement)
// PORTS
// i_clk        in   1       system clock; all logic on rising edge
// i_rst        in   1       synchronous active-high reset
// i_sample_l   in   DATA_W  left sample
// i_sample_r   in   DATA_W  right sample
// i_valid      in   1       sample pair offered
// o_ready      out  1       buffer can accept; transfer when i_valid & o_ready
// o_bclk       out  1       bit clock to codec
// o_lrck       out  1       0 = left slot, 1 = right slot
// o_sdata      out  1       serial data, MSB first
// o_underrun   out  1       1-cycle pulse: frame started with no new sample
// BEHAVIOUR
// - Reset, in any cycle: o_bclk, o_lrck, o_sdata, o_underrun = 0; o_ready = 0 while i_rst is high.
//   Counters, hold buffer, active registers and underrun arm flag are cleared.
// - BCLK period 0 starts on the first cycle after i_rst falls.
//   Each period lasts BCLK_DIV cycles: o_bclk is low for the first BCLK_DIV/2 cycles and high for the rest.
// - bit_cnt counts 0..2*SLOT_W-1, advances at each period start, and wraps to 0.
//   o_lrck and o_sdata change only at a period start and are constant for the whole period.
// - o_lrck = 0 for bit_cnt < SLOT_W, 1 otherwise.
//   The codec samples data on the o_bclk rising edge.
// - Slot position p = bit_cnt mod SLOT_W.
//   For p in 1..DATA_W, o_sdata = active[DATA_W-p] (I2S one-BCLK delay; MSB at p=1). Otherwise o_sdata = 0.
// - Hold buffer, one entry: o_ready = ~hold_full & ~i_rst. An accepted pair is written to hold and sets hold_full.
// - Frame load happens at the start of every period with bit_cnt = 0:
//   - If hold_full: active_l/r <= hold, with the MSB inverted when SIGN_FLIP=1; hold_full <= 0; the arm flag is set.
//   - Else: active is kept and the frame repeats. o_underrun pulses for 1 cycle if the arm flag is set.
// - A sample accepted in the same cycle as a frame load goes into hold. It plays in the next frame, not the current one.
// - The frame running at reset release transmits zeros. o_underrun stays silent until the first pair is accepted.
// - Latency from acceptance to MSB at o_sdata: from the next frame start, plus 1 BCLK period.
// - Reset mid-frame aborts the frame immediately; there is no partial-word completion.
// STRUCTURE
// - audio_pkg: DATA_W and SLOT_W defaults, plus typedef logic [DATA_W-1:0] sample_t.
// - Sub-module i2s_bit_timer: div_cnt/bit_cnt, o_bclk, and the period_start / frame_start strobes.
// - Top level: hold buffer, handshake, active registers, bit select and o_lrck/o_sdata registers.
// TESTING (defaults; frame = 2*32*4 = 256 cycles)
// - i_rst high 3 cycles -> all outputs 0 and o_ready = 0; cycle after release -> o_ready = 1, o_bclk low for 2 cycles then high for 2.
// - Push L=16'hA5F0, R=16'h0F0F during frame 0 -> from cycle 256:
//   - At o_bclk rising edges, left p=1..16 reads A5F0 MSB first, p=17..31 and p=0 read 0.
//   - o_lrck rises at cycle 256+128; the right slot reads 0F0F.
// - Two pairs pushed back-to-back in frame 0 -> second sees o_ready = 0 until cycle 256, then is accepted and plays in frame 2.
// - No push after one pair -> frame 2 repeats the same bits and o_underrun = 1 for exactly cycle 512.
//   With no pair ever pushed, o_underrun never asserts.
// - SIGN_FLIP=1, push L=16'h8000 -> left slot transmits all zeros; R=16'h7FFF transmits 16'hFFFF.
// - i_rst at cycle 300 -> next cycle all outputs 0 and hold cleared.
//   After release, bit timing restarts from period 0 and the first frame is zeros.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path defaults and the sample word type.
// Combinational only: no latency, no flow control.
package audio_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int SLOT_W_DEF = 32;

    typedef logic [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/i2s_bit_timer.sv
// I2S bit clock divider and frame bit counter with one-cycle-early period/frame ticks.
// Ticks lead the period start by one cycle so downstream registers change exactly at it; never stalls.
module i2s_bit_timer #(
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    output logic                        o_bclk,
    output logic                        o_period_tick,
    output logic                        o_frame_tick,
    output logic [$clog2(2*SLOT_W)-1:0] o_bit_nxt
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int FW = $clog2(2*SLOT_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [FW-1:0] BIT_LAST = FW'(2*SLOT_W - 1);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [FW-1:0] bit_cnt;

    // Ticks fire on the last cycle of a period; o_bit_nxt is the index of the period about to start.
    always_comb begin
        o_period_tick = (div_cnt == DIV_LAST);
        div_nxt       = o_period_tick ? '0 : div_cnt + 1'b1;
        o_bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        o_frame_tick  = o_period_tick && (bit_cnt == BIT_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            o_bclk  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            o_bclk  <= (div_nxt >= DIV_HALF);
            if (o_period_tick) begin
                bit_cnt <= o_bit_nxt;
            end
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: one-entry hold buffer feeding per-frame active L/R words, MSB one BCLK after LRCK edge.
// Accepted pair plays from the next frame start; o_ready drops while the hold buffer is full.
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SLOT_W    = SLOT_W_DEF,
    parameter int BCLK_DIV  = 4,
    parameter int SIGN_FLIP = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_sample_l,
    input  logic [DATA_W-1:0] i_sample_r,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_bclk,
    output logic              o_lrck,
    output logic              o_sdata,
    output logic              o_underrun
);

    localparam int PW = $clog2(SLOT_W);
    localparam int FW = PW + 1;
    localparam logic [DATA_W-1:0] FLIP_MASK =
        (SIGN_FLIP != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    logic              period_tick;
    logic              frame_tick;
    logic [FW-1:0]     bit_nxt;
    logic [DATA_W-1:0] hold_l, hold_r;
    logic [DATA_W-1:0] active_l, active_r;
    logic              hold_full;
    logic              armed;
    logic              accept;
    logic [PW-1:0]     pos;
    logic [DATA_W-1:0] word;
    logic              bit_sel;

    i2s_bit_timer #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_timer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_bclk        (o_bclk),
        .o_period_tick (period_tick),
        .o_frame_tick  (frame_tick),
        .o_bit_nxt     (bit_nxt)
    );

    assign o_ready = ~hold_full & ~i_rst;
    assign accept  = i_valid & o_ready;

    // Slot position 0 carries the I2S one-BCLK delay, so the frame load at position 0 never races the bit select.
    always_comb begin
        pos     = bit_nxt[PW-1:0];
        word    = bit_nxt[PW] ? active_r : active_l;
        bit_sel = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(pos) == DATA_W - i) begin
                bit_sel = word[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_l     <= '0;
            hold_r     <= '0;
            active_l   <= '0;
            active_r   <= '0;
            hold_full  <= 1'b0;
            armed      <= 1'b0;
            o_lrck     <= 1'b0;
            o_sdata    <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= 1'b0;
            if (frame_tick) begin
                if (hold_full) begin
                    active_l  <= hold_l ^ FLIP_MASK;
                    active_r  <= hold_r ^ FLIP_MASK;
                    hold_full <= 1'b0;
                    armed     <= 1'b1;
                end else begin
                    o_underrun <= armed;
                end
            end
            // accept implies hold is empty, so it never collides with the load above.
            if (accept) begin
                hold_l    <= i_sample_l;
                hold_r    <= i_sample_r;
                hold_full <= 1'b1;
            end
            if (period_tick) begin
                o_lrck  <= bit_nxt[PW];
                o_sdata <= bit_sel;
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench: two DUTs (SIGN_FLIP 0 and 1) share stimulus; each frame is rebuilt from BCLK-rise samples.
module tb_i2s_dac_tx;

    typedef struct {
        logic [15:0] l0, r0, l1, r1;
        logic        ur;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] sl, sr;
    logic        rdy0, bclk0, lrck0, sd0, ur0;
    logic        rdy1, bclk1, lrck1, sd1, ur1;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    logic [15:0] m_hl, m_hr, m_l0, m_r0, m_l1, m_r1;
    bit          m_full, m_armed;
    exp_t        exp_q[$];

    logic [63:0] b0, b1, lrb;
    logic        s0h, s1h, lrh;
    int          tbad, ur_other;
    bit          ur_at0;
    int          fr;

    always #5 clk = ~clk;

    i2s_dac_tx dut0 (
        .i_clk(clk), .i_rst(rst), .i_sample_l(sl), .i_sample_r(sr), .i_valid(valid),
        .o_ready(rdy0), .o_bclk(bclk0), .o_lrck(lrck0), .o_sdata(sd0), .o_underrun(ur0)
    );

    i2s_dac_tx #(.SIGN_FLIP(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_sample_l(sl), .i_sample_r(sr), .i_valid(valid),
        .o_ready(rdy1), .o_bclk(bclk1), .o_lrck(lrck1), .o_sdata(sd1), .o_underrun(ur1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_rec();
        b0 = '0; b1 = '0; lrb = '0;
        tbad = 0; ur_other = 0; ur_at0 = 1'b0;
    endtask

    task automatic monitor(input int c);
        int o, k, ph;
        o = c % 256; k = o / 4; ph = o % 4;
        if (bclk0 !== (ph >= 2)) tbad++;
        if (bclk1 !== bclk0) tbad++;
        if (lrck1 !== lrck0) tbad++;
        if (ph == 0) begin
            s0h = sd0; s1h = sd1; lrh = lrck0;
        end else if (sd0 !== s0h || sd1 !== s1h || lrck0 !== lrh) begin
            tbad++;
        end
        if (ph == 2) begin
            b0[k] = sd0; b1[k] = sd1; lrb[k] = lrck0;
        end
        if (ur0 === 1'b1) begin
            if (o == 0) ur_at0 = 1'b1;
            else ur_other++;
        end
        if (ur1 !== ur0) ur_other++;
    endtask

    task automatic end_frame(input int f);
        exp_t e;
        logic [15:0] l0, r0, l1, r1;
        int pad, lbad;
        check($sformatf("f%0d_queue", f), (exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int p = 1; p <= 16; p++) begin
            l0[16-p] = b0[p];  r0[16-p] = b0[32+p];
            l1[16-p] = b1[p];  r1[16-p] = b1[32+p];
        end
        pad = 0; lbad = 0;
        for (int k = 0; k < 64; k++) begin
            if ((k % 32) == 0 || (k % 32) > 16) begin
                if (b0[k] !== 1'b0 || b1[k] !== 1'b0) pad++;
            end
            if (lrb[k] !== (k >= 32)) lbad++;
        end
        check($sformatf("f%0d_left", f), l0, e.l0);
        check($sformatf("f%0d_right", f), r0, e.r0);
        check($sformatf("f%0d_left_flip", f), l1, e.l1);
        check($sformatf("f%0d_right_flip", f), r1, e.r1);
        check($sformatf("f%0d_pad_bits", f), pad, 0);
        check($sformatf("f%0d_lrck", f), lbad, 0);
        check($sformatf("f%0d_timing", f), tbad, 0);
        check($sformatf("f%0d_underrun", f), {ur_at0, (ur_other != 0)}, {e.ur, 1'b0});
    endtask

    // Reference model of the frame load decision taken at each frame boundary.
    task automatic frame_boundary();
        logic u;
        end_frame(cyc / 256 - 1);
        u = 1'b0;
        if (m_full) begin
            m_l0 = m_hl; m_r0 = m_hr;
            m_l1 = m_hl ^ 16'h8000; m_r1 = m_hr ^ 16'h8000;
            m_full = 1'b0; m_armed = 1'b1;
        end else begin
            u = m_armed;
        end
        exp_q.push_back('{m_l0, m_r0, m_l1, m_r1, u});
        clear_rec();
    endtask

    task automatic step();
        bit acc;
        logic [15:0] al, ar;
        acc = mon_en && valid && !m_full;
        al = sl; ar = sr;
        @(posedge clk);
        #1;
        if (mon_en) begin
            cyc++;
            if (cyc % 256 == 0) frame_boundary();
            if (acc) begin
                m_hl = al; m_hr = ar; m_full = 1'b1;
            end
            monitor(cyc);
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic release_rst();
        rst = 1'b0;
        cyc = 0;
        mon_en = 1'b1;
        m_full = 1'b0; m_armed = 1'b0;
        m_l0 = '0; m_r0 = '0; m_l1 = '0; m_r1 = '0;
        exp_q.delete();
        exp_q.push_back('{16'h0, 16'h0, 16'h0, 16'h0, 1'b0});
        clear_rec();
        monitor(0);
        #1;
        check("release_ready", {rdy0, rdy1}, 2'b11);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r, output int first_rdy);
        int n, rbad;
        n = 0; rbad = 0; first_rdy = -1;
        valid = 1'b1; sl = l; sr = r;
        while (n < 1000) begin
            if (rdy0 !== !m_full || rdy1 !== !m_full) rbad++;
            if (rdy0 === 1'b1 && first_rdy < 0) first_rdy = cyc;
            if (!m_full) begin
                step();
                break;
            end
            step();
            n++;
        end
        valid = 1'b0;
        check("push_ready_track", rbad, 0);
        check("push_bound", (n < 1000), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; sl = '0; sr = '0;
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_outputs", {rdy0, bclk0, lrck0, sd0, ur0, rdy1, bclk1, lrck1, sd1, ur1}, 0);
        end
        release_rst();

        run_to(10);
        push(16'hA5F0, 16'h0F0F, fr);
        check("push1_first_ready", fr, 10);
        push(16'h8000, 16'h7FFF, fr);
        check("push2_first_ready", fr, 256);

        run_to(1290);
        push(16'h5555, 16'hAAAA, fr);
        check("push3_first_ready", fr, 1290);

        run_to(1324);
        rst = 1'b1;
        mon_en = 1'b0;
        #1;
        check("reset_ready_comb", {rdy0, rdy1}, 2'b00);
        step();
        check("reset_mid_frame", {rdy0, bclk0, lrck0, sd0, ur0, rdy1, bclk1, lrck1, sd1, ur1}, 0);
        step();
        release_rst();

        run_to(512);
        push(16'h1234, 16'hFEDC, fr);
        check("push4_first_ready", fr, 512);
        run_to(1024);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
